pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
- Drives the PC-register enable, the four pipeline-register enables, the bubble/flush controls and the PC-source select.
- The datapath has no forwarding, so this block detects RAW hazards between the ID-stage sources and in-flight destinations and stalls until they clear.
- It also handles taken-branch redirect and an external halt/resume request, and keeps saturating stall/flush event counters.

Parameters:
RW, 5, register-address width
CW, 16, width of each saturating performance counter

Ports:
clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
id_rs  in  RW  first source register of instruction in ID
id_rt  in  RW  second source register of instruction in ID
id_rs_used  in  1  id_rs is actually read
id_rt_used  in  1  id_rt is actually read
ex_rd  in  RW  destination in EX
ex_regwrite  in  1  EX instruction writes ex_rd
mem_rd  in  RW  destination in MEM
mem_regwrite  in  1  MEM instruction writes mem_rd
wb_rd  in  RW  destination in WB
wb_regwrite  in  1  WB instruction writes wb_rd
branch_taken  in  1  EX-stage branch resolved taken (valid one cycle)
halt_req  in  1  level request to freeze the pipeline
pc_en  out  1  PC register load enable
pc_sel  out  1  0 = sequential PC, 1 = branch target
en_ifid  out  1  IF/ID enable
en_idex  out  1  ID/EX enable
en_exmem  out  1  EX/MEM enable
en_memwb  out  1  MEM/WB enable
flush_ifid  out  1  load NOP into IF/ID on next edge
flush_idex  out  1  load bubble (control bits 0) into ID/EX on next edge
halted  out  1  state == HALT
stall_cnt  out  CW  cycles spent stalling for hazards, saturating
flush_cnt  out  CW  taken-branch redirects, saturating

Behaviour:
- Reset (synchronous, active-high) is sampled on the rising edge of clk.
- While Reset is high:
  - state <= RUN; stall_cnt, flush_cnt <= 0.
  - Outputs are forced: pc_en=0, all en_*=0, pc_sel=0, flush_ifid=1, flush_idex=1, halted=0.
  - Reset mid-stall or mid-halt discards that state.
- Hazard term, combinational:
  - hz = (id_rs_used & id_rs!=0 & match(id_rs)) | (id_rt_used & id_rt!=0 & match(id_rt)).
  - match(r) = (ex_regwrite & ex_rd==r) | (mem_regwrite & mem_rd==r) | (wb_regwrite & wb_rd==r).
  - Register 0 never hazards.
  - A WB match counts as a hazard: the register bank writes at the edge and has no write-through.
- Outputs are combinational from state and current inputs (Moore/Mealy mix); state and counters are registered.
- RUN, no event: all en_*=1, pc_en=1, pc_sel=0, flushes 0.
- Priority each cycle: branch_taken > hz > halt_req.
- branch_taken (any state except HALT):
  - pc_sel=1, pc_en=1, flush_ifid=1, flush_idex=1; en_exmem=en_memwb=1.
  - The branch itself proceeds; the next state is RUN; flush_cnt +1.
  - The hazard on the squashed ID instruction is ignored that cycle.
- hz (RUN or STALL):
  - pc_en=0, en_ifid=0, flush_idex=1 (bubble); en_exmem=en_memwb=1; next state STALL; stall_cnt +1.
- STALL with hz=0: behaves as RUN this cycle; next state RUN (or HALT if halt_req).
- halt_req in RUN/STALL with no branch and no hz:
  - That cycle is a normal advance; next state HALT.
- HALT:
  - All en_*=0, pc_en=0, flushes 0, halted=1. Nothing moves; branch_taken and hz are ignored (pipeline frozen, inputs static).
  - halt_req=0 → RUN on the next edge.
- Counters:
  - Saturate at 2^CW-1; no wrap.
  - Increments are evaluated from the same-cycle combinational decision.
  - No increment while Reset is high.
- Maximum stall for one hazard: 3 cycles (producer in EX).
- Latency from hazard clear to ID advancing: 0 cycles (same cycle).

Test Plan:
- Reset held 3 cycles, then released with no hazards → during reset flush_ifid=flush_idex=1, en_*=0; first cycle after: all en_*=1, pc_en=1, counters 0.
- ID reads r5 (id_rs_used=1) while EX writes r5 and advances EX→MEM→WB over the next cycles → 3 consecutive stall cycles (pc_en=0, en_ifid=0, flush_idex=1); 4th cycle advances; stall_cnt=3.
- id_rs=0 with ex_rd=0, ex_regwrite=1 → no stall; stall_cnt stays 0.
- branch_taken=1 while hz=1 → pc_sel=1, flush_ifid=flush_idex=1, pc_en=1, no stall; flush_cnt=1, stall_cnt unchanged.
- halt_req=1 for 4 cycles from RUN → 1 advance cycle, then halted=1 with all enables 0 for 3 cycles; halt_req=0 → RUN next edge.
- Force 2^CW+5 hazard cycles with CW=4 → stall_cnt saturates at 15; Reset asserted in STALL → state RUN, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for a 5-stage IF/ID/EX/MEM/WB pipeline without forwarding.
// Detects RAW hazards between ID sources and in-flight destinations, stalls until
// they clear, redirects on taken branches, freezes on halt requests and counts
// stall cycles and branch redirects in saturating counters.
module pipe_hazard_ctrl #(
    parameter int unsigned RW = 5,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic [RW-1:0] mem_rd,
    input  logic          mem_regwrite,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_regwrite,
    input  logic          branch_taken,
    input  logic          halt_req,
    output logic          pc_en,
    output logic          pc_sel,
    output logic          en_ifid,
    output logic          en_idex,
    output logic          en_exmem,
    output logic          en_memwb,
    output logic          flush_ifid,
    output logic          flush_idex,
    output logic          halted,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StHalt
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] stall_cnt_q, flush_cnt_q;
    logic          rs_match, rt_match, hz;
    logic          stall_inc, flush_inc;

    // A WB producer still hazards: the register bank has no write-through.
    assign rs_match = (ex_regwrite  && (ex_rd  == id_rs)) ||
                      (mem_regwrite && (mem_rd == id_rs)) ||
                      (wb_regwrite  && (wb_rd  == id_rs));
    assign rt_match = (ex_regwrite  && (ex_rd  == id_rt)) ||
                      (mem_regwrite && (mem_rd == id_rt)) ||
                      (wb_regwrite  && (wb_rd  == id_rt));

    // Register 0 is hardwired, so it never creates a dependency.
    assign hz = (id_rs_used && (id_rs != '0) && rs_match) ||
                (id_rt_used && (id_rt != '0) && rt_match);

    // Per-cycle decision: outputs, next state and counter increments.
    always_comb begin
        pc_en      = 1'b1;
        pc_sel     = 1'b0;
        en_ifid    = 1'b1;
        en_idex    = 1'b1;
        en_exmem   = 1'b1;
        en_memwb   = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        halted     = 1'b0;
        state_d    = StRun;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        if (Reset) begin
            pc_en      = 1'b0;
            en_ifid    = 1'b0;
            en_idex    = 1'b0;
            en_exmem   = 1'b0;
            en_memwb   = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = StRun;
        end else if (state_q == StHalt) begin
            // Frozen pipeline: branch and hazard inputs are ignored.
            pc_en    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
            halted   = 1'b1;
            state_d  = halt_req ? StHalt : StRun;
        end else if (branch_taken) begin
            // Squash IF and ID; the hazard of the squashed ID instruction is moot.
            pc_sel     = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            flush_inc  = 1'b1;
            state_d    = StRun;
        end else if (hz) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, let older stages drain.
            pc_en      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
            stall_inc  = 1'b1;
            state_d    = StStall;
        end else begin
            // Normal advance; a halt request takes effect after this cycle.
            state_d = halt_req ? StHalt : StRun;
        end
    end

    // State register and saturating event counters.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
